// File: rtl/shift_add_mult_ctrl.sv
// Sequencer for an unsigned shift-and-add multiplier built around one external WIDTH-bit adder.
// Optional build macro: EARLY_TERM_EN (finish as soon as the remaining multiplier bits are zero).
//
// state  | meaning
// S_IDLE | waiting for start; product holds the last result
// S_CALC | one add/shift iteration per clock, count iterations left
// S_DONE | done pulse for one cycle, then back to S_IDLE
module shift_add_mult_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic [WIDTH-1:0]     add_a,
    output logic [WIDTH-1:0]     add_b,
    input  logic [WIDTH-1:0]     add_sum,
    input  logic                 add_cout,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] COUNT_INIT = CW'(WIDTH);
    localparam logic [CW-1:0] COUNT_LAST = CW'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state;
    logic [WIDTH-1:0]   m;
    logic [WIDTH-1:0]   acc;
    logic [WIDTH-1:0]   q;
    logic [CW-1:0]      count;

    logic [WIDTH-1:0]   s;
    logic               c;
    logic [2*WIDTH-1:0] step_val;
    logic [2*WIDTH-1:0] next_accq;
    logic               last_iter;

    assign add_a = acc;
    assign add_b = q[0] ? m : '0;

    // The adder result is only taken when the current multiplier bit is set.
    always_comb begin
        s = acc;
        c = 1'b0;
        if (q[0]) begin
            s = add_sum;
            c = add_cout;
        end
    end

    assign step_val = {c, s, q[WIDTH-1:1]};

`ifdef EARLY_TERM_EN
    logic [WIDTH-1:0]   pend_mask;
    logic               pend_zero;
    logic [2*WIDTH-1:0] skip_val;

    always_comb begin
        pend_mask = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (i < int'(count)) begin
                pend_mask[i] = 1'b1;
            end
        end
    end

    assign pend_zero = ((q & pend_mask) == '0);
    assign skip_val  = {acc, q} >> count;

    always_comb begin
        next_accq = step_val;
        last_iter = (count == COUNT_LAST);
        if (pend_zero) begin
            next_accq = skip_val;
            last_iter = 1'b1;
        end
    end
`else
    always_comb begin
        next_accq = step_val;
        last_iter = (count == COUNT_LAST);
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            m       <= '0;
            acc     <= '0;
            q       <= '0;
            count   <= '0;
            product <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        m     <= a;
                        q     <= b;
                        acc   <= '0;
                        count <= COUNT_INIT;
                        busy  <= 1'b1;
                        state <= S_CALC;
                    end
                end
                S_CALC: begin
                    {acc, q} <= next_accq;
                    count    <= count - COUNT_LAST;
                    if (last_iter) begin
                        product <= next_accq;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state   <= S_DONE;
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_add_mult_ctrl.sv
// Self-checking bench for shift_add_mult_ctrl: a timing/arithmetic model plus directed cases.
// Build with +define+EARLY_TERM_EN to exercise the early-termination variant.
module tb_shift_add_mult_ctrl;

    localparam int W = 4;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [W-1:0]     a;
    logic [W-1:0]     b;
    logic [W-1:0]     add_a;
    logic [W-1:0]     add_b;
    logic [W-1:0]     add_sum;
    logic             add_cout;
    logic             busy;
    logic             done;
    logic [2*W-1:0]   product;

    int tests;
    int fails;

    shift_add_mult_ctrl #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .a        (a),
        .b        (b),
        .add_a    (add_a),
        .add_b    (add_b),
        .add_sum  (add_sum),
        .add_cout (add_cout),
        .busy     (busy),
        .done     (done),
        .product  (product)
    );

    // External ripple-carry adder, carry-in tied low.
    assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected number of CALC cycles for multiplier value bv.
    function automatic int exp_lat(input logic [W-1:0] bv);
`ifdef EARLY_TERM_EN
        for (int k = 1; k <= W; k++) begin
            if ((bv >> (k - 1)) == '0) return k;
        end
        return W;
`else
        return W;
`endif
    endfunction

    // Transaction-level model: cycles left in the calculation, done flag, product.
    int             m_left;
    logic           m_done;
    logic [2*W-1:0] m_prod;
    logic [W-1:0]   m_a;
    logic [W-1:0]   m_b;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_left = 0;
            m_done = 1'b0;
            m_prod = '0;
            m_a    = '0;
            m_b    = '0;
        end else if (m_done) begin
            m_done = 1'b0;
        end else if (m_left > 0) begin
            m_left = m_left - 1;
            if (m_left == 0) begin
                m_done = 1'b1;
                m_prod = (2*W)'(m_a) * (2*W)'(m_b);
            end
        end else if (start) begin
            m_a    = a;
            m_b    = b;
            m_left = exp_lat(b);
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("model_busy", 32'(busy), 32'(m_left > 0));
            chk("model_done", 32'(done), 32'(m_done));
            chk("model_product", 32'(product), 32'(m_prod));
        end
    end

    logic saw_cout;
    always @(posedge clk) begin
        if (busy && add_cout && (add_b != '0)) saw_cout <= 1'b1;
    end

    task automatic start_op(input logic [W-1:0] av, input logic [W-1:0] bv);
        @(negedge clk);
        start = 1'b1;
        a     = av;
        b     = bv;
        @(negedge clk);
        start = 1'b0;
        a     = ~av;
        b     = ~bv;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (!done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        if (!done) chk("done_timeout", 32'(done), 32'd1);
    endtask

    task automatic run_case(input string name, input logic [W-1:0] av, input logic [W-1:0] bv,
                            input logic [2*W-1:0] exp_prod, input int lat_exp);
        int lat;
        start_op(av, bv);
        chk({name, "_busy_e0"}, 32'(busy), 32'd1);
        wait_done(lat);
        chk({name, "_latency"}, 32'(lat), 32'(lat_exp));
        chk({name, "_product"}, 32'(product), 32'(exp_prod));
        @(negedge clk);
        chk({name, "_done_one_cycle"}, 32'(done), 32'd0);
        chk({name, "_idle_busy"}, 32'(busy), 32'd0);
    endtask

`ifdef EARLY_TERM_EN
    localparam int L_9_0 = 1;
    localparam int L_7_2 = 3;
    localparam int L_5_3 = 3;
`else
    localparam int L_9_0 = 4;
    localparam int L_7_2 = 4;
    localparam int L_5_3 = 4;
`endif

    initial begin
        int dc;
        tests    = 0;
        fails    = 0;
        saw_cout = 1'b0;
        rst_n    = 1'b0;
        start    = 1'b0;
        a        = '0;
        b        = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_product", 32'(product), 32'd0);
        chk("reset_add_a", 32'(add_a), 32'd0);
        chk("reset_add_b", 32'(add_b), 32'd0);

        run_case("m13x11", 4'd13, 4'd11, 8'h8F, 4);
        saw_cout = 1'b0;
        run_case("m15x15", 4'd15, 4'd15, 8'hE1, 4);
        chk("m15x15_cout_seen", 32'(saw_cout), 32'd1);
        run_case("m9x0", 4'd9, 4'd0, 8'h00, L_9_0);
        run_case("m0x9", 4'd0, 4'd9, 8'h00, 4);
        run_case("m7x2", 4'd7, 4'd2, 8'h0E, L_7_2);

        // Starts during CALC and DONE must be ignored.
        start_op(4'd5, 4'd3);
        dc = 0;
        for (int k = 0; k <= L_5_3 + 3; k++) begin
            if (done) dc++;
            if (k == L_5_3 - 2 || k == L_5_3) begin
                start = 1'b1;
                a     = 4'd1;
                b     = 4'd1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        chk("ignore_done_pulses", 32'(dc), 32'd1);
        chk("ignore_product", 32'(product), 32'h0F);
        chk("ignore_busy_after", 32'(busy), 32'd0);
        run_case("m2x3_after_ignore", 4'd2, 4'd3, 8'h06, L_5_3);

        // Asynchronous reset mid-calculation.
        start_op(4'd6, 4'd6);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_busy", 32'(busy), 32'd0);
        chk("async_done", 32'(done), 32'd0);
        chk("async_product", 32'(product), 32'd0);
        chk("async_add_a", 32'(add_a), 32'd0);
        chk("async_add_b", 32'(add_b), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        dc = 0;
        repeat (6) begin
            @(negedge clk);
            if (done) dc++;
        end
        chk("async_no_done", 32'(dc), 32'd0);
        run_case("m3x4_after_reset", 4'd3, 4'd4, 8'h0C, 4);

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
